// File: rtl/jpc_pkg.sv
// Shared constants and types for the jpc core front end.
`timescale 1ns/1ps
package jpc_pkg;

  localparam int JPC_XLEN          = 32;
  localparam int JPC_ADDRESS_WIDTH = 32;

  localparam logic [JPC_XLEN-1:0] JPC_RESET_PC = 32'h0000_0000;
  // addi x0, x0, 0
  localparam logic [JPC_XLEN-1:0] JPC_NOP      = 32'h0000_0013;

  typedef struct packed {
    logic [JPC_XLEN-1:0] pc;
    logic [JPC_XLEN-1:0] instr;
  } jpc_bundle_t;

  function automatic logic [JPC_XLEN-1:0] jpc_align(input logic [JPC_XLEN-1:0] a);
    return {a[JPC_XLEN-1:2], 2'b00};
  endfunction

  function automatic logic [JPC_ADDRESS_WIDTH-1:0] jpc_word_addr(input logic [JPC_XLEN-1:0] a);
    return {2'b00, a[JPC_XLEN-1:2]};
  endfunction

endpackage

// File: rtl/jpc_ifetch_if.sv
// Fetch-stage bus bundle: instruction BRAM port, redirect input and decode handshake.
`timescale 1ns/1ps
interface jpc_ifetch_if;
  import jpc_pkg::*;

  logic [JPC_ADDRESS_WIDTH-1:0] imem_addr;
  logic [JPC_ADDRESS_WIDTH-1:0] imem_din;
  logic                         imem_we;
  logic [JPC_ADDRESS_WIDTH-1:0] imem_dout;

  logic                         redirect_valid;
  logic [JPC_XLEN-1:0]          redirect_pc;

  logic                         if_valid;
  logic                         if_ready;
  logic [JPC_XLEN-1:0]          if_pc;
  logic [JPC_XLEN-1:0]          if_instr;

  modport master (
    output imem_addr, imem_din, imem_we,
    input  imem_dout,
    input  redirect_valid, redirect_pc,
    output if_valid, if_pc, if_instr,
    input  if_ready
  );

  modport slave (
    input  imem_addr, imem_din, imem_we,
    output imem_dout,
    output redirect_valid, redirect_pc,
    input  if_valid, if_pc, if_instr,
    output if_ready
  );

endinterface

// File: rtl/jpc_ifetch_queue.sv
// Small circular FIFO of {pc, instr} bundles; flush wins over push and pop.
`timescale 1ns/1ps
module jpc_ifetch_queue
  import jpc_pkg::*;
#(
  parameter  int QDEPTH = 2,
  localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1,
  localparam int CW     = $clog2(QDEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  jpc_bundle_t   din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output jpc_bundle_t   head
);

  jpc_bundle_t   mem_q [QDEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    full    = (count == CW'(QDEPTH));
    empty   = (count == '0);
    do_pop  = pop && !empty && !flush;
    // A pop in the same cycle frees the slot the push lands in.
    do_push = push && !flush && (!full || do_pop);
    head    = mem_q[rd_ptr];
  end

  // storage: data only, no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr] <= din;
    end
  end

  // pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/jpc_ifetch.sv
// jpc instruction-fetch stage: owns the PC, drives the BRAM address and queues
// returned words for decode; execute redirects flush everything in flight.
`timescale 1ns/1ps
module jpc_ifetch
  import jpc_pkg::*;
#(
  parameter logic [JPC_XLEN-1:0] RESET_PC = JPC_RESET_PC,
  parameter int                  QDEPTH   = 2
) (
  input logic           clk,
  input logic           rst_n,
  jpc_ifetch_if.master  bus
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [JPC_XLEN-1:0] pc_p0;
  logic [JPC_XLEN-1:0] ia_p0;
  logic                issue_p0;
  logic [31:0]         occ_p0;

  logic                vld_p1;
  logic [JPC_XLEN-1:0] pc_p1;

  logic                q_push;
  logic                q_pop;
  logic                q_full;
  logic                q_empty;
  logic [CW-1:0]       q_count;
  jpc_bundle_t         q_din;
  jpc_bundle_t         q_head;

  // p0: choose the issue address and decide whether a slot is free for it
  always_comb begin
    ia_p0    = bus.redirect_valid ? jpc_align(bus.redirect_pc) : pc_p0;
    q_pop    = !q_empty && bus.if_ready && !bus.redirect_valid;
    // Queued words plus the one still in the BRAM must leave room for this one.
    occ_p0   = 32'(q_count) + 32'(vld_p1) - 32'(q_pop);
    issue_p0 = bus.redirect_valid || (occ_p0 < 32'(QDEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_p0  <= jpc_align(RESET_PC);
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= issue_p0;
      if (issue_p0) begin
        pc_p0 <= ia_p0 + 32'd4;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (issue_p0) begin
      pc_p1 <= ia_p0;
    end
  end

  // p1: BRAM word is on imem_dout; a redirect this cycle drops it
  always_comb begin
    q_push = vld_p1 && !bus.redirect_valid;
    q_din  = '{pc: pc_p1, instr: bus.imem_dout};
  end

  jpc_ifetch_queue #(
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (q_push),
    .pop   (q_pop),
    .flush (bus.redirect_valid),
    .din   (q_din),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count),
    .head  (q_head)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(q_push && q_full));

  // p2: queue head toward decode; zeroed while empty so reset shows zeros
  always_comb begin
    bus.imem_addr = jpc_word_addr(ia_p0);
    bus.imem_din  = '0;
    bus.imem_we   = 1'b0;
    bus.if_valid  = !q_empty;
    bus.if_pc     = q_empty ? '0 : q_head.pc;
    bus.if_instr  = q_empty ? '0 : q_head.instr;
  end

endmodule

// File: tb/tb_jpc_ifetch.sv
// Bench for jpc_ifetch: directed cycle table, reset/wrap cases and a randomized
// run checked against a stream-level model of the delivered instruction sequence.
`timescale 1ns/1ps
module tb_jpc_ifetch;
  import jpc_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  jpc_ifetch_if bus_a ();
  jpc_ifetch_if bus_b ();

  jpc_ifetch #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut_a (
    .clk (clk), .rst_n (rst_n), .bus (bus_a)
  );
  jpc_ifetch #(.RESET_PC(32'hFFFF_FFF8), .QDEPTH(2)) dut_b (
    .clk (clk), .rst_n (rst_n), .bus (bus_b)
  );

  logic [31:0] mem [1024];

  always @(posedge clk) begin
    bus_a.imem_dout <= mem[bus_a.imem_addr[9:0]];
    bus_b.imem_dout <= mem[bus_b.imem_addr[9:0]];
  end

  int total = 0;
  int bad   = 0;

  function automatic logic [31:0] word_at(input logic [31:0] pc);
    return mem[pc[11:2]];
  endfunction

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic ev, input logic [31:0] epc);
    vec_t v;
    v.rdy = rdy; v.rv = rv; v.rpc = rpc; v.ev = ev; v.epc = epc;
    return v;
  endfunction

  vec_t tbl [30];

  initial begin
    logic [31:0] exp_next;
    logic        rv_prev;
    logic        hold_prev;
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic [31:0] bpc;

    for (int i = 0; i < 1024; i++) mem[i] = 32'(i) + 32'h100;
    bus_a.imem_dout = JPC_NOP;
    bus_b.imem_dout = JPC_NOP;

    // Per-cycle stimulus and expected head, cycle 0 = first cycle after release.
    tbl[0]  = mk(1, 0, 0,      0, 0);
    tbl[1]  = mk(1, 0, 0,      0, 0);
    tbl[2]  = mk(1, 0, 0,      1, 32'h0);
    tbl[3]  = mk(1, 0, 0,      1, 32'h4);
    tbl[4]  = mk(1, 0, 0,      1, 32'h8);
    tbl[5]  = mk(0, 0, 0,      1, 32'hC);
    tbl[6]  = mk(0, 0, 0,      1, 32'hC);
    tbl[7]  = mk(0, 0, 0,      1, 32'hC);
    tbl[8]  = mk(0, 0, 0,      1, 32'hC);
    tbl[9]  = mk(0, 0, 0,      1, 32'hC);
    tbl[10] = mk(1, 0, 0,      1, 32'hC);
    tbl[11] = mk(0, 0, 0,      1, 32'h10);
    tbl[12] = mk(1, 1, 32'h40, 1, 32'h10);
    tbl[13] = mk(1, 0, 0,      0, 0);
    tbl[14] = mk(1, 0, 0,      1, 32'h40);
    tbl[15] = mk(1, 1, 32'h80, 1, 32'h44);
    tbl[16] = mk(1, 1, 32'h200, 0, 0);
    tbl[17] = mk(1, 0, 0,      0, 0);
    tbl[18] = mk(1, 0, 0,      1, 32'h200);
    tbl[19] = mk(1, 0, 0,      1, 32'h204);
    tbl[20] = mk(1, 1, 32'h43, 1, 32'h208);
    tbl[21] = mk(1, 0, 0,      0, 0);
    tbl[22] = mk(1, 0, 0,      1, 32'h40);
    tbl[23] = mk(1, 0, 0,      1, 32'h44);
    tbl[24] = mk(0, 0, 0,      1, 32'h48);
    tbl[25] = mk(0, 0, 0,      1, 32'h48);
    tbl[26] = mk(0, 1, 32'h300, 1, 32'h48);
    tbl[27] = mk(1, 0, 0,      0, 0);
    tbl[28] = mk(1, 0, 0,      1, 32'h300);
    tbl[29] = mk(1, 0, 0,      1, 32'h304);

    rst_n = 1'b0;
    bus_a.if_ready = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0;
    bus_b.if_ready = 1'b1; bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1 ("reset if_valid", bus_a.if_valid, 1'b0);
    chk32("reset if_pc",    bus_a.if_pc,    32'h0);
    chk32("reset if_instr", bus_a.if_instr, 32'h0);
    chk1 ("reset imem_we",  bus_a.imem_we,  1'b0);
    chk32("reset imem_din", bus_a.imem_din, 32'h0);

    @(posedge clk); #1;
    for (int i = 0; i < 30; i++) begin
      bus_a.if_ready       = tbl[i].rdy;
      bus_a.redirect_valid = tbl[i].rv;
      bus_a.redirect_pc    = tbl[i].rpc;
      if (i == 0) rst_n = 1'b1;
      @(negedge clk);
      chk1($sformatf("tbl%0d if_valid", i), bus_a.if_valid, tbl[i].ev);
      if (tbl[i].ev) begin
        chk32($sformatf("tbl%0d if_pc", i),    bus_a.if_pc,    tbl[i].epc);
        chk32($sformatf("tbl%0d if_instr", i), bus_a.if_instr, word_at(tbl[i].epc));
      end
      if (tbl[i].rv)
        chk32($sformatf("tbl%0d imem_addr", i), bus_a.imem_addr, {2'b00, tbl[i].rpc[31:2]});
      chk1($sformatf("tbl%0d imem_we", i), bus_a.imem_we, 1'b0);
      // Second instance starts near the top of the address space and must wrap.
      if (i < 2) begin
        chk1($sformatf("wrap%0d if_valid", i), bus_b.if_valid, 1'b0);
      end else begin
        bpc = 32'hFFFF_FFF8 + 32'(4 * (i - 2));
        chk1 ($sformatf("wrap%0d if_valid", i), bus_b.if_valid, 1'b1);
        chk32($sformatf("wrap%0d if_pc", i),    bus_b.if_pc,    bpc);
        chk32($sformatf("wrap%0d if_instr", i), bus_b.if_instr, word_at(bpc));
      end
      @(posedge clk); #1;
    end

    // Fill the queue, then assert reset mid-cycle.
    bus_a.if_ready = 1'b0; bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = '0;
    @(posedge clk); #2;
    chk1 ("prefill if_valid", bus_a.if_valid, 1'b1);
    chk32("prefill if_pc",    bus_a.if_pc,    32'h308);
    #1 rst_n = 1'b0;
    #1;
    chk1 ("async rst if_valid", bus_a.if_valid, 1'b0);
    chk32("async rst if_pc",    bus_a.if_pc,    32'h0);
    chk32("async rst if_instr", bus_a.if_instr, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk1 ($sformatf("in rst%0d if_valid", k), bus_a.if_valid, 1'b0);
      chk1 ($sformatf("in rst%0d imem_we", k),  bus_a.imem_we,  1'b0);
    end
    @(posedge clk); #1;
    bus_a.if_ready = 1'b1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k < 2) begin
        chk1($sformatf("restart%0d if_valid", k), bus_a.if_valid, 1'b0);
      end else begin
        chk1 ($sformatf("restart%0d if_valid", k), bus_a.if_valid, 1'b1);
        chk32($sformatf("restart%0d if_pc", k),    bus_a.if_pc,    32'(4 * (k - 2)));
        chk32($sformatf("restart%0d if_instr", k), bus_a.if_instr, word_at(32'(4 * (k - 2))));
      end
      @(posedge clk); #1;
    end

    // Randomized run: the model tracks only the next PC decode should see.
    exp_next  = 32'h8;
    rv_prev   = 1'b0;
    hold_prev = 1'b0;
    hold_pc   = '0;
    hold_instr = '0;
    for (int n = 0; n < 3000; n++) begin
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 15) == 0);
      rpc = $urandom;
      bus_a.if_ready       = rdy;
      bus_a.redirect_valid = rv;
      bus_a.redirect_pc    = rpc;
      @(negedge clk);
      chk1($sformatf("rnd%0d if_valid", n), bus_a.if_valid, !rv_prev);
      if (hold_prev) begin
        chk32($sformatf("rnd%0d held pc", n),    bus_a.if_pc,    hold_pc);
        chk32($sformatf("rnd%0d held instr", n), bus_a.if_instr, hold_instr);
      end
      if (rv) begin
        chk32($sformatf("rnd%0d imem_addr", n), bus_a.imem_addr, {2'b00, rpc[31:2]});
        exp_next = {rpc[31:2], 2'b00};
      end else if (bus_a.if_valid && rdy) begin
        chk32($sformatf("rnd%0d if_pc", n),    bus_a.if_pc,    exp_next);
        chk32($sformatf("rnd%0d if_instr", n), bus_a.if_instr, word_at(exp_next));
        exp_next = exp_next + 32'd4;
      end
      hold_prev  = bus_a.if_valid && !rdy && !rv;
      hold_pc    = bus_a.if_pc;
      hold_instr = bus_a.if_instr;
      rv_prev    = rv;
      @(posedge clk); #1;
    end
    chk1 ("final imem_we",  bus_a.imem_we,  1'b0);
    chk32("final imem_din", bus_a.imem_din, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
